// File: rtl/instr_issue_unit_if.sv
// rtl/instr_issue_unit_if.sv - queue pop-side and issue-group bundle for instr_issue_unit
// Optional perf counter signals appear when ISSUE_PERF_COUNTERS_EN is defined.
interface instr_issue_unit_if #(
   parameter int LOG_SUPERSCALAR_WIDTH = 3,
   parameter int ISSUE_WIDTH           = 3,
   parameter int ADDR_W                = 18
);
   // queue head (first-word-fall-through)
   logic                              queue_not_empty;
   logic                              queue_pop;
   logic [1:0]                        q_instr_type;
   logic [LOG_SUPERSCALAR_WIDTH:0]    q_copy_count;
   logic [ADDR_W-1:0]                 q_cache_addr;
   logic [ADDR_W-1:0]                 q_main_mem_addr;
   logic [ADDR_W-1:0]                 q_d_cache_addr;
   logic [ADDR_W-1:0]                 q_d_main_mem_addr;
   logic [8:0]                        q_arith_instr;
   logic [2:0]                        q_ram_instr;
   logic [6:0]                        q_ld_st_instr;

   // issue group towards the backend
   logic                              issue_ready;
   logic [ISSUE_WIDTH-1:0]            issue_valid;
   logic [1:0]                        issue_instr_type;
   logic [17:0]                       issue_payload;
   logic                              issue_skip;
   logic [ISSUE_WIDTH*ADDR_W-1:0]     issue_cache_addr;
   logic [ISSUE_WIDTH*ADDR_W-1:0]     issue_main_mem_addr;

   // host status
   logic                              program_complete;
   logic                              issue_error;

`ifdef ISSUE_PERF_COUNTERS_EN
   logic [31:0]                       perf_uops_issued;
   logic [31:0]                       perf_stall_cycles;
`endif

   // issue unit side
   modport slave (
      input  queue_not_empty, q_instr_type, q_copy_count,
      input  q_cache_addr, q_main_mem_addr, q_d_cache_addr, q_d_main_mem_addr,
      input  q_arith_instr, q_ram_instr, q_ld_st_instr, issue_ready,
      output queue_pop, issue_valid, issue_instr_type, issue_payload, issue_skip,
      output issue_cache_addr, issue_main_mem_addr, program_complete, issue_error
`ifdef ISSUE_PERF_COUNTERS_EN
      , output perf_uops_issued, perf_stall_cycles
`endif
   );

   // queue / backend / host side
   modport master (
      output queue_not_empty, q_instr_type, q_copy_count,
      output q_cache_addr, q_main_mem_addr, q_d_cache_addr, q_d_main_mem_addr,
      output q_arith_instr, q_ram_instr, q_ld_st_instr, issue_ready,
      input  queue_pop, issue_valid, issue_instr_type, issue_payload, issue_skip,
      input  issue_cache_addr, issue_main_mem_addr, program_complete, issue_error
`ifdef ISSUE_PERF_COUNTERS_EN
      , input perf_uops_issued, perf_stall_cycles
`endif
   );
endinterface

// File: rtl/instr_issue_unit.sv
// rtl/instr_issue_unit.sv - pops queue entries and expands them into up to ISSUE_WIDTH micro-ops per cycle
// Define ISSUE_PERF_COUNTERS_EN to add the perf_uops_issued / perf_stall_cycles counters.
module instr_issue_unit #(
   parameter int LOG_SUPERSCALAR_WIDTH = 3,
   parameter int ISSUE_WIDTH           = 3,
   parameter int ADDR_W                = 18
) (
   input logic               clk,
   input logic               reset,
   instr_issue_unit_if.slave bus
);
   localparam int CNT_W     = LOG_SUPERSCALAR_WIDTH + 1;
   localparam int MAX_COUNT = 1 << LOG_SUPERSCALAR_WIDTH;

   localparam logic [1:0] T_ARITH    = 2'd2;
   localparam logic [1:0] T_PROG_END = 2'd3;

   typedef enum logic [1:0] {S_EMPTY, S_ACTIVE, S_END} state_t;

   state_t            state, next_state;
   logic [CNT_W-1:0]  remaining;
   logic [CNT_W-1:0]  issued;
   logic [CNT_W-1:0]  lane_n;
   logic [1:0]        h_type;
   logic [ADDR_W-1:0] h_cache, h_d_cache, h_mm, h_d_mm;
   logic [8:0]        h_arith;
   logic [2:0]        h_ram;
   logic [6:0]        h_ld_st;
   logic              error_q;
   logic              hold_done;
   logic              pop;
   logic              accept;
   logic              q_legal;

   // lanes issued this cycle: min(remaining, ISSUE_WIDTH)
   always_comb begin
      lane_n = remaining;
      if (int'(remaining) > ISSUE_WIDTH)
         lane_n = CNT_W'(ISSUE_WIDTH);
   end

   // pop decision and next state; holding register frees up when the last group is accepted
   always_comb begin
      next_state = state;
      accept     = (state == S_ACTIVE) && bus.issue_ready;
      q_legal    = (bus.q_copy_count != '0) && (bus.q_copy_count <= CNT_W'(MAX_COUNT));
      hold_done  = (state != S_ACTIVE) || (accept && (int'(remaining) <= ISSUE_WIDTH));
      pop        = bus.queue_not_empty && hold_done && !reset;
      if (hold_done) begin
         next_state = S_EMPTY;
         if (pop) begin
            if (bus.q_instr_type == T_PROG_END)
               next_state = S_END;
            else if (q_legal)
               next_state = S_ACTIVE;
         end
      end
   end

   // state register
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         state <= S_EMPTY;
      else
         state <= next_state;
   end

   // holding register, progress counters and sticky error
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         remaining <= '0;
         issued    <= '0;
         h_type    <= '0;
         h_cache   <= '0;
         h_d_cache <= '0;
         h_mm      <= '0;
         h_d_mm    <= '0;
         h_arith   <= '0;
         h_ram     <= '0;
         h_ld_st   <= '0;
         error_q   <= 1'b0;
      end else begin
         if (accept) begin
            if (int'(remaining) <= ISSUE_WIDTH) begin
               remaining <= '0;
               issued    <= '0;
            end else begin
               remaining <= remaining - lane_n;
               issued    <= issued + lane_n;
            end
         end
         if (pop) begin
            h_type    <= bus.q_instr_type;
            h_cache   <= bus.q_cache_addr;
            h_d_cache <= bus.q_d_cache_addr;
            h_mm      <= bus.q_main_mem_addr;
            h_d_mm    <= bus.q_d_main_mem_addr;
            h_arith   <= bus.q_arith_instr;
            h_ram     <= bus.q_ram_instr;
            h_ld_st   <= bus.q_ld_st_instr;
            issued    <= '0;
            // PROG_END and dropped entries never load a count
            if (bus.q_instr_type != T_PROG_END && q_legal)
               remaining <= bus.q_copy_count;
            else
               remaining <= '0;
            if (bus.q_instr_type != T_PROG_END && !q_legal)
               error_q <= 1'b1;
         end
      end
   end

   // issue group drive; everything reads 0 unless an entry is actively issuing
   always_comb begin
      logic active;
      logic [ADDR_W-1:0] off;
      active               = (state == S_ACTIVE);
      bus.queue_pop        = pop;
      bus.program_complete = (state == S_END);
      bus.issue_error      = error_q;
      bus.issue_valid      = '0;
      bus.issue_instr_type = '0;
      bus.issue_payload    = '0;
      bus.issue_skip       = 1'b0;
      bus.issue_cache_addr    = '0;
      bus.issue_main_mem_addr = '0;
      if (active) begin
         bus.issue_instr_type = h_type;
         bus.issue_payload    = {h_arith, h_ram, h_ld_st[6:1]};
         bus.issue_skip       = h_ld_st[0];
      end
      for (int j = 0; j < ISSUE_WIDTH; j++) begin
         off = ADDR_W'(issued) + ADDR_W'(j);
         if (active && (j < int'(lane_n)))
            bus.issue_valid[j] = 1'b1;
         if (active && h_type != T_ARITH) begin
            bus.issue_cache_addr[j*ADDR_W +: ADDR_W]    = h_cache + off * h_d_cache;
            bus.issue_main_mem_addr[j*ADDR_W +: ADDR_W] = h_mm + off * h_d_mm;
         end
      end
   end

`ifdef ISSUE_PERF_COUNTERS_EN
   logic [31:0] uops_q, stall_q;

   // accepted micro-op count and backpressure cycle count
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         uops_q  <= '0;
         stall_q <= '0;
      end else begin
         if (accept)
            uops_q <= uops_q + 32'(lane_n);
         if (state == S_ACTIVE && !bus.issue_ready)
            stall_q <= stall_q + 32'd1;
      end
   end

   assign bus.perf_uops_issued  = uops_q;
   assign bus.perf_stall_cycles = stall_q;
`endif
endmodule

// File: tb/tb_instr_issue_unit.sv
// tb/tb_instr_issue_unit.sv - directed self-checking bench for instr_issue_unit
module tb_instr_issue_unit;
   localparam int LSW = 3;
   localparam int IW  = 3;
   localparam int AW  = 18;

   logic clk;
   logic reset;
   int   checks;
   int   errors;

   instr_issue_unit_if #(.LOG_SUPERSCALAR_WIDTH(LSW), .ISSUE_WIDTH(IW), .ADDR_W(AW)) bus ();

   instr_issue_unit #(.LOG_SUPERSCALAR_WIDTH(LSW), .ISSUE_WIDTH(IW), .ADDR_W(AW)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   // clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // bench-side FWFT queue contents
   logic [1:0]    e_type  [0:15];
   logic [LSW:0]  e_count [0:15];
   logic [AW-1:0] e_ca    [0:15];
   logic [AW-1:0] e_dca   [0:15];
   logic [AW-1:0] e_mm    [0:15];
   logic [AW-1:0] e_dmm   [0:15];
   logic [8:0]    e_ar    [0:15];
   logic [2:0]    e_rm    [0:15];
   logic [6:0]    e_ls    [0:15];
   int head;
   int tail;

   task automatic push(input logic [1:0] t, input logic [LSW:0] c,
                       input logic [AW-1:0] ca, input logic [AW-1:0] dca,
                       input logic [AW-1:0] mm, input logic [AW-1:0] dmm,
                       input logic [8:0] ar, input logic [2:0] rm, input logic [6:0] ls);
      e_type[tail] = t;  e_count[tail] = c;
      e_ca[tail] = ca;   e_dca[tail] = dca;
      e_mm[tail] = mm;   e_dmm[tail] = dmm;
      e_ar[tail] = ar;   e_rm[tail] = rm;  e_ls[tail] = ls;
      tail = tail + 1;
   endtask

   task automatic drive_q();
      bus.queue_not_empty = (head < tail);
      if (head < tail) begin
         bus.q_instr_type      = e_type[head];
         bus.q_copy_count      = e_count[head];
         bus.q_cache_addr      = e_ca[head];
         bus.q_d_cache_addr    = e_dca[head];
         bus.q_main_mem_addr   = e_mm[head];
         bus.q_d_main_mem_addr = e_dmm[head];
         bus.q_arith_instr     = e_ar[head];
         bus.q_ram_instr       = e_rm[head];
         bus.q_ld_st_instr     = e_ls[head];
      end else begin
         bus.q_instr_type      = '0;
         bus.q_copy_count      = '0;
         bus.q_cache_addr      = '0;
         bus.q_d_cache_addr    = '0;
         bus.q_main_mem_addr   = '0;
         bus.q_d_main_mem_addr = '0;
         bus.q_arith_instr     = '0;
         bus.q_ram_instr       = '0;
         bus.q_ld_st_instr     = '0;
      end
   endtask

   // one clock: the queue advances if the DUT popped before the edge
   task automatic tick();
      logic p;
      #1;
      p = bus.queue_pop;
      @(posedge clk);
      #1;
      if (p) head = head + 1;
      drive_q();
      #1;
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks = checks + 1;
      assert (obs === exp)
      else begin
         errors = errors + 1;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [AW-1:0] lane(input logic [IW*AW-1:0] v, input int j);
      return v[j*AW +: AW];
   endfunction

   initial begin
      checks = 0;
      errors = 0;
      head   = 0;
      tail   = 0;
      reset  = 1'b1;
      bus.issue_ready = 1'b0;
      drive_q();
      #12;
      check("rst_valid", bus.issue_valid, 0);
      check("rst_pc", bus.program_complete, 0);
      check("rst_err", bus.issue_error, 0);
      check("rst_cache", bus.issue_cache_addr, 0);
      @(posedge clk);
      #1;
      reset = 1'b0;
      #1;

      // 1: RAM count 8 -> 3,3,2
      bus.issue_ready = 1'b1;
      push(2'd1, 4'd8, 18'd100, 18'd4, 18'd1000, 18'd16, 9'd0, 3'b101, 7'd0);
      drive_q();
      #1;
      check("t1_pop", bus.queue_pop, 1);
      tick();
      check("t1_g1_valid", bus.issue_valid, 3'b111);
      check("t1_g1_type", bus.issue_instr_type, 2'd1);
      check("t1_g1_payload", bus.issue_payload, 18'h00140);
      check("t1_g1_pop", bus.queue_pop, 0);
      for (int j = 0; j < 3; j++) begin
         check("t1_g1_cache", lane(bus.issue_cache_addr, j), 100 + 4*j);
         check("t1_g1_mm", lane(bus.issue_main_mem_addr, j), 1000 + 16*j);
      end
      tick();
      check("t1_g2_valid", bus.issue_valid, 3'b111);
      for (int j = 0; j < 3; j++) begin
         check("t1_g2_cache", lane(bus.issue_cache_addr, j), 112 + 4*j);
         check("t1_g2_mm", lane(bus.issue_main_mem_addr, j), 1048 + 16*j);
      end
      tick();
      check("t1_g3_valid", bus.issue_valid, 3'b011);
      check("t1_g3_cache0", lane(bus.issue_cache_addr, 0), 124);
      check("t1_g3_cache1", lane(bus.issue_cache_addr, 1), 128);
      check("t1_g3_mm0", lane(bus.issue_main_mem_addr, 0), 1096);
      check("t1_g3_mm1", lane(bus.issue_main_mem_addr, 1), 1112);
      tick();
      check("t1_idle_valid", bus.issue_valid, 0);

      // 2: two ARITH count 1 back-to-back
      push(2'd2, 4'd1, 18'd7, 18'd1, 18'd9, 18'd1, 9'h1A5, 3'd0, 7'd0);
      push(2'd2, 4'd1, 18'd7, 18'd1, 18'd9, 18'd1, 9'h0F3, 3'd0, 7'd0);
      drive_q();
      tick();
      check("t2_a1_valid", bus.issue_valid, 3'b001);
      check("t2_a1_type", bus.issue_instr_type, 2'd2);
      check("t2_a1_payload", bus.issue_payload, {9'h1A5, 9'd0});
      check("t2_a1_cache", lane(bus.issue_cache_addr, 0), 0);
      check("t2_a1_pop", bus.queue_pop, 1);
      tick();
      check("t2_a2_valid", bus.issue_valid, 3'b001);
      check("t2_a2_payload", bus.issue_payload, {9'h0F3, 9'd0});
      tick();
      check("t2_idle_valid", bus.issue_valid, 0);

      // 3: LD_ST count 5 with 4 stalled cycles
      push(2'd0, 4'd5, 18'd200, 18'd1, 18'd50, 18'd2, 9'd0, 3'd0, 7'b1011011);
      drive_q();
      tick();
      bus.issue_ready = 1'b0;
      for (int c = 0; c < 4; c++) begin
         if (c != 0) tick();
         check("t3_stall_valid", bus.issue_valid, 3'b111);
         check("t3_stall_cache0", lane(bus.issue_cache_addr, 0), 200);
         check("t3_stall_cache2", lane(bus.issue_cache_addr, 2), 202);
         check("t3_stall_mm2", lane(bus.issue_main_mem_addr, 2), 54);
      end
      check("t3_payload", bus.issue_payload, 18'h0002D);
      check("t3_skip", bus.issue_skip, 1);
      bus.issue_ready = 1'b1;
      tick();
      check("t3_g2_valid", bus.issue_valid, 3'b011);
      check("t3_g2_cache0", lane(bus.issue_cache_addr, 0), 203);
      check("t3_g2_cache1", lane(bus.issue_cache_addr, 1), 204);
      check("t3_g2_mm1", lane(bus.issue_main_mem_addr, 1), 58);
      tick();
      check("t3_idle_valid", bus.issue_valid, 0);

      // 4: LD_ST count 2 then PROG_END
      push(2'd0, 4'd2, 18'd5, 18'd1, 18'd5, 18'd1, 9'd0, 3'd0, 7'd0);
      push(2'd3, 4'd0, 18'd0, 18'd0, 18'd0, 18'd0, 9'd0, 3'd0, 7'd0);
      drive_q();
      tick();
      check("t4_ls_valid", bus.issue_valid, 3'b011);
      check("t4_ls_pc", bus.program_complete, 0);
      tick();
      check("t4_end_pc", bus.program_complete, 1);
      check("t4_end_valid", bus.issue_valid, 0);
      tick();
      check("t4_after_pc", bus.program_complete, 0);
      check("t4_after_valid", bus.issue_valid, 0);

      // 5: illegal count, then ARITH, then wrapping addresses
      push(2'd1, 4'd0, 18'd1, 18'd1, 18'd1, 18'd1, 9'd0, 3'd0, 7'd0);
      push(2'd2, 4'd1, 18'd0, 18'd0, 18'd0, 18'd0, 9'h055, 3'd0, 7'd0);
      push(2'd1, 4'd2, 18'h3FFFC, 18'd4, 18'h3FFF0, 18'h10, 9'd0, 3'd0, 7'd0);
      drive_q();
      tick();
      check("t5_err", bus.issue_error, 1);
      check("t5_drop_valid", bus.issue_valid, 0);
      check("t5_drop_pop", bus.queue_pop, 1);
      tick();
      check("t5_arith_valid", bus.issue_valid, 3'b001);
      check("t5_arith_payload", bus.issue_payload, {9'h055, 9'd0});
      tick();
      check("t5_wrap_valid", bus.issue_valid, 3'b011);
      check("t5_wrap_cache0", lane(bus.issue_cache_addr, 0), 18'h3FFFC);
      check("t5_wrap_cache1", lane(bus.issue_cache_addr, 1), 18'h00000);
      check("t5_wrap_mm1", lane(bus.issue_main_mem_addr, 1), 18'h00000);
      check("t5_err_sticky", bus.issue_error, 1);
      tick();

      // 6: async reset mid-entry
      push(2'd1, 4'd8, 18'd10, 18'd1, 18'd0, 18'd0, 9'd0, 3'd0, 7'd0);
      drive_q();
      tick();
      check("t6_g1_valid", bus.issue_valid, 3'b111);
      push(2'd2, 4'd1, 18'd0, 18'd0, 18'd0, 18'd0, 9'h111, 3'd0, 7'd0);
      tick();
      check("t6_g2_cache0", lane(bus.issue_cache_addr, 0), 13);
      #2;
      reset = 1'b1;
      #1;
      check("t6_rst_valid", bus.issue_valid, 0);
      check("t6_rst_cache", bus.issue_cache_addr, 0);
      check("t6_rst_pop", bus.queue_pop, 0);
      check("t6_rst_err", bus.issue_error, 0);
      check("t6_rst_pc", bus.program_complete, 0);
      tick();
      check("t6_hold_valid", bus.issue_valid, 0);
      reset = 1'b0;
      tick();
      check("t6_next_valid", bus.issue_valid, 3'b001);
      check("t6_next_type", bus.issue_instr_type, 2'd2);
      check("t6_next_pc", bus.program_complete, 0);
      tick();
      check("t6_idle_valid", bus.issue_valid, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
